lcd_view_ctrl: RTL and testbench

//  Parametrised image-view controller for the LCD path. Stores one IMG_W x IMG_H

---
 rtl/lcd_view_pkg.sv | 34 +++
 rtl/lcd_img_mem.sv | 32 +++
 rtl/lcd_view_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_view_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lcd_view_pkg.sv
// Shared types and width helpers for the LCD image-view controller.
//  cmd_e   : command encodings carried on the 3-bit cmd port
//  state_e : controller FSM states
//  width_of / max_of : elaboration-time helpers for derived widths
package lcd_view_pkg;

  typedef enum logic [2:0] {
    CmdLoad   = 3'd0,
    CmdZoomIn = 3'd1,
    CmdFit    = 3'd2,
    CmdRight  = 3'd3,
    CmdLeft   = 3'd4,
    CmdUp     = 3'd5,
    CmdDown   = 3'd6,
    CmdRedraw = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPrep,
    StEmit
  } state_e;

  // Register width able to hold 0..v-1; never below one bit.
  function automatic int unsigned width_of(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_img_mem.sv
// Image store: Depth x DW register array, one synchronous write port and one
// combinational read port.
//  i_clk   : clock
//  i_we    : write enable
//  i_waddr : write address
//  i_wdata : write data
//  i_raddr : read address
//  o_rdata : read data (combinational)
module lcd_img_mem
  import lcd_view_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned Depth = 108,
  parameter int unsigned AW    = 7
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_view_ctrl.sv
// Image-view controller: loads one IMG_W x IMG_H raster and streams a WIN_W x WIN_H
// view, either a subsampled fit of the whole image or a 1:1 zoom window with
// clamped panning.
//  clk, reset   : clock, synchronous active-high reset
//  datain       : pixel stream during LOAD
//  cmd/cmd_valid: command input, ignored while busy
//  dataout      : view pixel, qualified by output_valid
//  busy         : command in progress
//  zoom_mode    : 1 = zoom view, 0 = fit view
module lcd_view_ctrl
  import lcd_view_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 12,
  parameter int unsigned IMG_H = 9,
  parameter int unsigned WIN_W = 4,
  parameter int unsigned WIN_H = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy,
  output logic          zoom_mode
);

  localparam int unsigned NPix = IMG_W * IMG_H;
  localparam int unsigned NWin = WIN_W * WIN_H;
  localparam int unsigned SX   = IMG_W / WIN_W;
  localparam int unsigned SY   = IMG_H / WIN_H;
  localparam int unsigned OX0  = (IMG_W - WIN_W + 1) / 2;
  localparam int unsigned OY0  = (IMG_H - WIN_H + 1) / 2;
  localparam int unsigned XMAX = IMG_W - WIN_W;
  localparam int unsigned YMAX = IMG_H - WIN_H;
  localparam int unsigned AW   = width_of(NPix);
  localparam int unsigned XW   = width_of(IMG_W);
  localparam int unsigned YW   = width_of(IMG_H);
  localparam int unsigned IW   = width_of(WIN_W);
  localparam int unsigned JW   = width_of(WIN_H);
  localparam int unsigned CW   = width_of(max_of(NPix, NWin));

  state_e        r_state, w_state_nxt;
  cmd_e          r_cmd, w_cmd_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [IW-1:0] r_bi, w_bi_nxt;
  logic [JW-1:0] r_bj, w_bj_nxt;
  logic [XW-1:0] r_ox, w_ox_nxt;
  logic [YW-1:0] r_oy, w_oy_nxt;
  logic          r_zoom, w_zoom_nxt;
  logic          r_img_valid, w_img_valid_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_oval, w_oval_nxt;
  logic [DW-1:0] r_dout, w_dout_nxt;

  logic          w_we;
  logic [AW-1:0] w_col, w_row, w_raddr;
  logic [DW-1:0] w_rdata;

  // Zoom reads the window at the origin; fit picks the centre of each SX x SY cell.
  always_comb begin
    if (r_zoom) begin
      w_col = AW'(r_ox) + AW'(r_bi);
      w_row = AW'(r_oy) + AW'(r_bj);
    end else begin
      w_col = AW'(SX) * AW'(r_bi) + AW'(SX / 2);
      w_row = AW'(SY) * AW'(r_bj) + AW'(SY / 2);
    end
    w_raddr = w_row * AW'(IMG_W) + w_col;
  end

  lcd_img_mem #(
    .DW   (DW),
    .Depth(NPix),
    .AW   (AW)
  ) u_mem (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(AW'(r_cnt)),
    .i_wdata(datain),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cmd       <= CmdLoad;
      r_cnt       <= '0;
      r_bi        <= '0;
      r_bj        <= '0;
      r_ox        <= XW'(OX0);
      r_oy        <= YW'(OY0);
      r_zoom      <= 1'b0;
      r_img_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_oval      <= 1'b0;
      r_dout      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bi        <= w_bi_nxt;
      r_bj        <= w_bj_nxt;
      r_ox        <= w_ox_nxt;
      r_oy        <= w_oy_nxt;
      r_zoom      <= w_zoom_nxt;
      r_img_valid <= w_img_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_oval      <= w_oval_nxt;
      r_dout      <= w_dout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_cnt_nxt       = r_cnt;
    w_bi_nxt        = r_bi;
    w_bj_nxt        = r_bj;
    w_ox_nxt        = r_ox;
    w_oy_nxt        = r_oy;
    w_zoom_nxt      = r_zoom;
    w_img_valid_nxt = r_img_valid;
    w_busy_nxt      = r_busy;
    w_oval_nxt      = 1'b0;
    w_dout_nxt      = r_dout;
    w_we            = 1'b0;

    unique case (r_state)
      StIdle: begin
        // busy may still be high here after a guarded (no image) command.
        w_busy_nxt = 1'b0;
        if (cmd_valid && !r_busy) begin
          w_busy_nxt  = 1'b1;
          w_cmd_nxt   = cmd_e'(cmd);
          w_cnt_nxt   = '0;
          w_bi_nxt    = '0;
          w_bj_nxt    = '0;
          w_state_nxt = (cmd_e'(cmd) == CmdLoad) ? StLoad : StPrep;
        end
      end
      StLoad: begin
        w_we      = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(NPix - 1)) begin
          w_img_valid_nxt = 1'b1;
          w_zoom_nxt      = 1'b0;
          w_cmd_nxt       = CmdFit;
          w_cnt_nxt       = '0;
          w_state_nxt     = StPrep;
        end
      end
      StPrep: begin
        if (!r_img_valid) begin
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StEmit;
          case (r_cmd)
            CmdZoomIn: begin
              if (!r_zoom) begin
                w_ox_nxt   = XW'(OX0);
                w_oy_nxt   = YW'(OY0);
                w_zoom_nxt = 1'b1;
              end
            end
            CmdFit:   w_zoom_nxt = 1'b0;
            CmdRight: if (r_zoom && r_ox < XW'(XMAX)) w_ox_nxt = r_ox + XW'(1);
            CmdLeft:  if (r_zoom && r_ox != '0) w_ox_nxt = r_ox - XW'(1);
            CmdDown:  if (r_zoom && r_oy < YW'(YMAX)) w_oy_nxt = r_oy + YW'(1);
            CmdUp:    if (r_zoom && r_oy != '0) w_oy_nxt = r_oy - YW'(1);
            default:  ;
          endcase
        end
      end
      StEmit: begin
        w_oval_nxt = 1'b1;
        w_dout_nxt = w_rdata;
        w_cnt_nxt  = r_cnt + CW'(1);
        if (r_bi == IW'(WIN_W - 1)) begin
          w_bi_nxt = '0;
          w_bj_nxt = r_bj + JW'(1);
        end else begin
          w_bi_nxt = r_bi + IW'(1);
        end
        if (r_cnt == CW'(NWin - 1)) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign dataout      = r_dout;
  assign output_valid = r_oval;
  assign busy         = r_busy;
  assign zoom_mode    = r_zoom;

endmodule

// File: tb/tb_lcd_view_ctrl.sv
module tb_lcd_view_ctrl;

  localparam int IMG_W = 12;
  localparam int NPIX  = 108;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] datain;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] dataout;
  logic       output_valid;
  logic       busy;
  logic       zoom_mode;

  lcd_view_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .datain      (datain),
    .cmd         (cmd),
    .cmd_valid   (cmd_valid),
    .dataout     (dataout),
    .output_valid(output_valid),
    .busy        (busy),
    .zoom_mode   (zoom_mode)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int exp_q[$];
  int mx, my;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Scoreboard monitor: every presented beat must match the next queued value.
  always @(negedge clk) begin
    if (output_valid) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL beat_unexpected: got %0d, expected no beat", dataout);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(dataout) == e) n_pass++;
        else $display("FAIL beat_data: got %0d, expected %0d", dataout, e);
      end
    end
  end

  task automatic push_fit();
    int fit_px[16] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
    foreach (fit_px[n]) exp_q.push_back(fit_px[n]);
  endtask

  task automatic push_zoom(input int nbeats);
    for (int n = 0; n < nbeats; n++) exp_q.push_back((my + n / 4) * IMG_W + mx + n % 4);
  endtask

  // Issue one command; k counts edges after the accept edge.
  task automatic run_cmd(input string name, input logic [2:0] c, input int exp_first,
                         input int exp_low, input bit pulse);
    int first = -1;
    int lowk  = -1;
    @(negedge clk);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 400 && lowk < 0; k++) begin
      if (k > 0) @(negedge clk);
      datain = 8'(k);
      if (k == 0) check({name, "_accept_busy"}, int'(busy), 1);
      if (pulse && k == 0) begin
        cmd       = 3'd0;
        cmd_valid = 1'b1;
      end
      if (pulse && k == 1) cmd_valid = 1'b0;
      if (output_valid && first < 0) first = k;
      if (!busy) lowk = k;
    end
    check({name, "_first_beat"}, first, exp_first);
    check({name, "_busy_low"}, lowk, exp_low);
    @(negedge clk);
    check({name, "_valid_drop"}, int'(output_valid), 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    datain    = '0;
    cmd       = '0;
    cmd_valid = 1'b0;
    mx        = 4;
    my        = 3;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(output_valid), 0);
    check("rst_dataout", int'(dataout), 0);
    check("rst_zoom", int'(zoom_mode), 0);
    reset = 1'b0;

    // No image yet: guarded, busy for two cycles, pulse while busy dropped.
    run_cmd("zoom_noimg", 3'd1, -1, 2, 1'b1);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("noimg_idle_busy", int'(busy), 0);
    end

    push_fit();
    run_cmd("load", 3'd0, NPIX + 2, NPIX + 17, 1'b0);
    check("load_zoom", int'(zoom_mode), 0);

    mx = 4; my = 3;
    push_zoom(16);
    run_cmd("zoom_in", 3'd1, 2, 17, 1'b0);
    check("zoom_in_mode", int'(zoom_mode), 1);

    for (int n = 0; n < 5; n++) begin
      if (mx < 8) mx++;
      push_zoom(16);
      run_cmd("right", 3'd3, 2, 17, 1'b0);
    end
    check("right_clamp_row0", (my * IMG_W + mx), 44);

    for (int n = 0; n < 4; n++) begin
      if (my > 0) my--;
      push_zoom(16);
      run_cmd("up", 3'd5, 2, 17, 1'b0);
    end

    push_fit();
    run_cmd("fit", 3'd2, 2, 17, 1'b0);
    check("fit_mode", int'(zoom_mode), 0);
    push_fit();
    run_cmd("right_fit", 3'd3, 2, 17, 1'b0);
    check("right_fit_mode", int'(zoom_mode), 0);
    push_fit();
    run_cmd("redraw_fit", 3'd7, 2, 17, 1'b0);
    check("redraw_fit_mode", int'(zoom_mode), 0);

    mx = 4; my = 3;
    push_zoom(16);
    run_cmd("zoom_again", 3'd1, 2, 17, 1'b0);

    // Reset while the 7th beat of a redraw is on the output.
    push_zoom(7);
    @(negedge clk);
    cmd       = 3'd7;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_beat7_valid", int'(output_valid), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_valid", int'(output_valid), 0);
    check("rst_mid_dataout", int'(dataout), 0);
    check("rst_mid_zoom", int'(zoom_mode), 0);
    check("rst_mid_queue", exp_q.size(), 0);
    exp_q.delete();

    run_cmd("zoom_after_rst", 3'd1, -1, 2, 1'b0);
    check("zoom_after_rst_mode", int'(zoom_mode), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
